// File: rtl/serial_rx_deshifter.sv
//------------------------------------------------------------------------------
// Module      : serial_rx_deshifter
// Description : LSB-first serial-to-parallel receiver with a held valid/ack
//               output word and a sticky overrun flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_rx_deshifter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  serial_in,
    input  logic                  bit_valid,
    input  logic                  data_ack,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (bit_valid && (cnt_q == LAST_BIT)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SHIFT: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // A word published on the DONE exit wins over any ack on the same edge.
    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;
        if (valid_q && data_ack) begin
            valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (bit_valid) begin
                    shift_d = {serial_in, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = (cnt_q == LAST_BIT) ? '0 : cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                data_out_d = shift_q;
                valid_d    = 1'b1;
                if (valid_q && !data_ack) begin
                    ovr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

`default_nettype wire

// File: doc/serial_rx_deshifter.md
Name: serial_rx_deshifter

Overview:
Serial-in/parallel-out receive controller and datapath, the receiving end of the Load/Shift transmit path. A Moore FSM arms on `start` and shifts in `DATA_WIDTH` serial bits, LSB first, qualified by `bit_valid`. It then presents the assembled word on a held valid/ack output interface and flags overrun. It sits between the serial link and the parallel consumer logic.

Parameters:
- DATA_WIDTH, 8, number of bits per received word (≥2).
- CNT_W, $clog2(DATA_WIDTH), width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- start  input  1  arm reception; honoured only in IDLE.
- serial_in  input  1  serial data bit.
- bit_valid  input  1  serial_in is sampled this cycle when high (SHIFT state only).
- data_ack  input  1  consumer accepts data_out this cycle.
- busy  output  1  high in SHIFT and DONE (Moore).
- done  output  1  one-cycle pulse while in DONE (Moore).
- data_out  output  DATA_WIDTH  last completed word, registered.
- data_valid  output  1  data_out holds an unacknowledged word.
- overrun  output  1  sticky: a word completed while the previous was unacknowledged.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, shift_reg=0, bit_cnt=0, data_out=0, data_valid=0, overrun=0.
  - busy=0, done=0.
  - Reset overrides every other input, including mid-frame; a partial word is discarded.
- FSM states IDLE, SHIFT, DONE. Outputs are a function of state only (Moore).
  - IDLE: busy=0, done=0. If start=1, go to SHIFT and clear shift_reg and bit_cnt. Otherwise stay. bit_valid is ignored.
  - SHIFT: busy=1. If bit_valid=1, shift_reg <= {serial_in, shift_reg[DATA_WIDTH-1:1]} (first received bit ends in bit 0) and bit_cnt increments. If bit_valid=1 and bit_cnt==DATA_WIDTH-1, go to DONE and reset bit_cnt to 0. If bit_valid=0, hold everything, with no timeout. start is ignored.
  - DONE: busy=1, done=1, lasting exactly one cycle, then unconditionally IDLE. On that exit edge, data_out <= shift_reg and data_valid <= 1.
  - Any illegal state encoding goes to IDLE.
- Latency: the last bit is sampled at edge k. done is high during cycle k→k+1. data_out and data_valid update at edge k+1. A new start is accepted no earlier than edge k+2 (IDLE).
- Minimum frame: 1 start cycle, then DATA_WIDTH valid cycles, then 1 DONE cycle.
- data_valid / data_ack:
  - data_valid=1 and data_ack=1 at an edge clears data_valid.
  - data_ack with data_valid=0 has no effect.
  - data_out is stable while data_valid=1, unless overwritten by a new word.
- Overrun:
  - On the DONE exit edge, if data_valid=1 and data_ack=0, then overrun <= 1 and data_out is overwritten with the new word (newest wins).
  - overrun is sticky and cleared only by reset.
- Simultaneous ack and DONE exit on the same edge: the new word loads, data_valid stays 1, and overrun is not set.
- Width rules: bit_cnt counts 0..DATA_WIDTH-1 and never wraps beyond. shift_reg is exactly DATA_WIDTH bits.

Test Plan:
1. Reset held low 3 cycles with random inputs -> data_out=0, data_valid=0, overrun=0, busy=0, done=0 throughout. After release, stays in IDLE.
2. start=1 for 1 cycle, then 8 contiguous bit_valid cycles with serial_in = 1,0,1,0,0,1,0,1 -> done pulses 1 cycle after the 8th bit. One cycle later, data_out=0xA5 and data_valid=1. data_ack=1 for one cycle -> data_valid=0.
3. Same frame as scenario 2 with bit_valid=0 gaps of 1–3 cycles between bits, and start=1 pulsed mid-frame -> data_out=0xA5. Mid-frame start has no effect, and busy stays 1 across the gaps.
4. Receive 0x3C without acking, then receive 0xC3 -> data_out=0xC3, data_valid=1, overrun=1. overrun stays 1 after a later ack.
5. Receive 0x11, keep it unacked, receive 0xFF with data_ack=1 on the DONE-exit edge -> data_out=0xFF, data_valid=1, overrun=0.
6. Reset pulsed low after 4 of 8 bits, then a full frame of 0x5A -> busy=0 immediately after the reset edge. The next frame yields exactly 0x5A with no remnant bits.
